seven_seg_capture: RTL



---
 rtl/seven_seg_pkg.sv | 26 ++
 rtl/seg_stable_detect.sv | 44 ++++
 rtl/seven_seg_capture.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: active-low glyph table, decoder and digit count.
// Segment order is {g,f,e,d,c,b,a}; a 0 bit means the segment is lit.
package seven_seg_pkg;

    localparam int unsigned NUM_DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] HEX2SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Returns {valid, nibble}; patterns outside the table decode as invalid zero.
    function automatic logic [4:0] seg2hex(input logic [6:0] seg);
        logic [4:0] r;
        r = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (seg == HEX2SEG[i]) r = {1'b1, 4'(i)};
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_stable_detect.sv
// Two-flop synchroniser followed by a settle counter; strobes once per stable input value.
// dout is the settled value and is meaningful while strobe is high.
module seg_stable_detect #(
    parameter int unsigned WIDTH         = 12,
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             strobe
);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] prev_q;
    logic [7:0]       cnt_q;
    logic             same;

    assign same = (sync2_q == prev_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
            prev_q  <= '1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            if (!same) begin
                cnt_q <= '0;
            end else if (cnt_q != 8'(SETTLE_CYCLES)) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    // Fires on the cycle whose edge moves the counter onto its saturation value.
    assign strobe = same && (cnt_q == 8'(SETTLE_CYCLES - 1));
    assign dout   = prev_q;

endmodule

// File: rtl/seven_seg_capture.sv
// Reconstructs the word shown on a scanned 4-digit active-low seven-segment bus.
// Optional partial-frame timeout is built when SEG_CAP_TIMEOUT_EN is defined.
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  i_an,
    input  logic [7:0]  i_seg,
    output logic [15:0] o_data,
    output logic [3:0]  o_dots,
    output logic        o_valid,
    output logic        o_err,
    output logic        o_stale
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("seven_seg_capture: parameter out of range");
    end

    logic [11:0] settled;
    logic        strobe;
    logic        timeout;

    seg_stable_detect #(
        .WIDTH        (12),
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_detect (
        .clk   (clk),
        .rst_n (rst_n),
        .din   ({i_an, i_seg}),
        .dout  (settled),
        .strobe(strobe)
    );

    logic [3:0] an;
    logic [7:0] seg;
    logic [3:0] an_low;
    logic       one_hot;
    logic [1:0] dig;
    logic [4:0] dec;

    assign an      = settled[11:8];
    assign seg     = settled[7:0];
    assign an_low  = ~an;
    assign one_hot = (an_low != '0) && ((an_low & (an_low - 4'd1)) == '0);
    assign dec     = seg2hex(seg[6:0]);

    always_comb begin
        dig = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (!an[i]) dig = 2'(i);
        end
    end

`ifdef SEG_CAP_TIMEOUT_EN
    logic [31:0] idle_q;

    assign timeout = !strobe && (idle_q == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                idle_q <= '0;
        else if (strobe || timeout) idle_q <= '0;
        else                       idle_q <= idle_q + 32'd1;
    end
`else
    assign timeout = 1'b0;
`endif

    logic [3:0]  mask_q, mask_d;
    logic [15:0] shadow_q, shadow_d;
    logic [3:0]  sdots_q, sdots_d;
    logic        bad_q, bad_d;
    logic [15:0] data_d;
    logic [3:0]  dots_d;
    logic        stale_d, valid_d, err_d;

    always_comb begin
        mask_d   = mask_q;
        shadow_d = shadow_q;
        sdots_d  = sdots_q;
        bad_d    = bad_q;
        data_d   = o_data;
        dots_d   = o_dots;
        stale_d  = o_stale;
        valid_d  = 1'b0;
        err_d    = 1'b0;

        // A full mask means the previous edge captured the last digit of the frame.
        if (mask_q == '1) begin
            if (bad_q) begin
                err_d = 1'b1;
            end else begin
                valid_d = 1'b1;
                data_d  = shadow_q;
                dots_d  = sdots_q;
                stale_d = 1'b0;
            end
            mask_d = '0;
            bad_d  = 1'b0;
        end

        if (timeout) begin
            mask_d  = '0;
            bad_d   = 1'b0;
            stale_d = 1'b1;
        end

        if (strobe) begin
            if (one_hot) begin
                shadow_d[{dig, 2'b00} +: 4] = dec[3:0];
                sdots_d[dig]                = ~seg[7];
                mask_d[dig]                 = 1'b1;
                if (!dec[4]) bad_d = 1'b1;
            end else if (an != '1) begin
                err_d  = 1'b1;
                mask_d = '0;
                bad_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q   <= '0;
            shadow_q <= '0;
            sdots_q  <= '0;
            bad_q    <= 1'b0;
            o_data   <= '0;
            o_dots   <= '0;
            o_valid  <= 1'b0;
            o_err    <= 1'b0;
            o_stale  <= 1'b1;
        end else begin
            mask_q   <= mask_d;
            shadow_q <= shadow_d;
            sdots_q  <= sdots_d;
            bad_q    <= bad_d;
            o_data   <= data_d;
            o_dots   <= dots_d;
            o_valid  <= valid_d;
            o_err    <= err_d;
            o_stale  <= stale_d;
        end
    end

endmodule
